// File: rtl/imm_pkg.sv
// imm_pkg -- shared definitions for the immediate encoder and immediate generator.
//   imm_type_e : immediate format selector (110/111 are treated as I)
//   err_code_e : encoder status codes
//   CntWidth   : width of the handshake/error counters
package imm_pkg;

   typedef enum logic [2:0] {
      ImmI    = 3'b000,
      ImmS    = 3'b001,
      ImmU    = 3'b010,
      ImmJ    = 3'b011,
      ImmB    = 3'b100,
      ImmIu   = 3'b101,
      ImmRsv6 = 3'b110,
      ImmRsv7 = 3'b111
   } imm_type_e;

   typedef enum logic [1:0] {
      ErrOk        = 2'b00,
      ErrRange     = 2'b01,
      ErrAlign     = 2'b10,
      ErrRoundTrip = 2'b11
   } err_code_e;

   localparam int unsigned CntWidth = 16;

   // Fold the reserved encodings onto plain I so downstream logic sees six formats only.
   function automatic imm_type_e norm_type(input logic [2:0] t);
      return (t inside {3'b110, 3'b111}) ? ImmI : imm_type_e'(t);
   endfunction

endpackage

// File: rtl/imm_field_pack.sv
// imm_field_pack -- combinational placement of an immediate into an instruction word.
// Ports:
//   typ       : normalized immediate format
//   imm       : immediate value (pass zero to clear all immediate bit positions)
//   base_word : instruction with non-immediate fields already placed
//   word      : base_word with the format's immediate bits overwritten
module imm_field_pack
   import imm_pkg::*;
(
   input  imm_type_e   typ,
   input  logic [31:0] imm,
   input  logic [31:0] base_word,
   output logic [31:0] word
);

   always_comb begin
      word = base_word;
      unique case (typ)
         ImmS: begin
            word[31:25] = imm[11:5];
            word[11:7]  = imm[4:0];
         end
         ImmU: word[31:12] = imm[31:12];
         ImmJ: begin
            word[31]    = imm[20];
            word[30:21] = imm[10:1];
            word[20]    = imm[11];
            word[19:12] = imm[19:12];
         end
         ImmB: begin
            word[31]    = imm[12];
            word[30:25] = imm[10:5];
            word[11:8]  = imm[4:1];
            word[7]     = imm[11];
         end
         default: word[31:20] = imm[11:0]; // I and I-unsigned
      endcase
   end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder -- two-stage pipelined RISC-V immediate encoder with range/alignment checks.
// Optional feature: define IMM_ROUNDTRIP_CHECK_EN to decode the packed word in S2 and flag
// a round-trip mismatch (err_code 11).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : request handshake
//   imm_type, imm_value   : immediate format and value
//   base_word             : instruction template (immediate positions ignored)
//   out_valid/out_ready   : result handshake
//   out_word              : encoded instruction (immediate cleared on error)
//   out_err, err_code     : error flag and code
//   cnt_clr               : synchronous counter clear (wins over increment)
//   enc_count, err_count  : saturating handshake / error-handshake counters
module imm_encoder
   import imm_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2:0]          imm_type,
   input  logic [31:0]         imm_value,
   input  logic [31:0]         base_word,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [31:0]         out_word,
   output logic                out_err,
   output logic [1:0]          err_code,
   input  logic                cnt_clr,
   output logic [CntWidth-1:0] enc_count,
   output logic [CntWidth-1:0] err_count
);

   function automatic logic all_eq(input logic [31:0] v, input int unsigned lsb);
      logic [31:0] m;
      m = 32'hFFFF_FFFF << lsb;
      return ((v & m) == m) || ((v & m) == 32'h0);
   endfunction

   imm_type_e   typ;
   logic        range_err, align_err, chk_err;
   err_code_e   chk_code;
   logic [31:0] packed_word;

   assign typ = norm_type(imm_type);

   always_comb begin
      range_err = 1'b0;
      align_err = 1'b0;
      unique case (typ)
         ImmU:  range_err = |imm_value[11:0];
         ImmJ: begin
            align_err = imm_value[0];
            range_err = !all_eq(imm_value, 20);
         end
         ImmB: begin
            align_err = imm_value[0];
            range_err = !all_eq(imm_value, 12);
         end
         ImmIu: range_err = |imm_value[31:12];
         default: range_err = !all_eq(imm_value, 11); // I and S
      endcase
   end

   assign chk_err  = range_err | align_err;
   assign chk_code = align_err ? ErrAlign : (range_err ? ErrRange : ErrOk);

   // Packing a zero immediate clears exactly the format's immediate bit positions.
   imm_field_pack u_pack (
      .typ       (typ),
      .imm       (chk_err ? 32'h0 : imm_value),
      .base_word (base_word),
      .word      (packed_word)
   );

   // Handshake
   logic s1_valid, s2_ready, s1_adv, in_fire, out_fire;
   assign s2_ready = !out_valid || out_ready;
   assign s1_adv   = s1_valid && s2_ready;
   assign in_ready = !s1_valid || s2_ready;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   logic [31:0] s1_word;
   logic        s1_err;
   err_code_e   s1_code;
   logic        s2_err;
   err_code_e   s2_code;

`ifdef IMM_ROUNDTRIP_CHECK_EN
   imm_type_e   s1_type;
   logic [31:0] s1_imm;
   logic [31:0] rt_imm;
   logic        rt_bad;

   always_comb begin
      unique case (s1_type)
         ImmS:  rt_imm = {{20{s1_word[31]}}, s1_word[31:25], s1_word[11:7]};
         ImmU:  rt_imm = {s1_word[31:12], 12'h0};
         ImmJ:  rt_imm = {{11{s1_word[31]}}, s1_word[31], s1_word[19:12], s1_word[20],
                          s1_word[30:21], 1'b0};
         ImmB:  rt_imm = {{19{s1_word[31]}}, s1_word[31], s1_word[7], s1_word[30:25],
                          s1_word[11:8], 1'b0};
         ImmIu: rt_imm = {20'h0, s1_word[31:20]};
         default: rt_imm = {{20{s1_word[31]}}, s1_word[31:20]};
      endcase
   end

   assign rt_bad  = !s1_err && (rt_imm != s1_imm);
   assign s2_err  = s1_err | rt_bad;
   assign s2_code = rt_bad ? ErrRoundTrip : s1_code;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_type <= ImmI;
         s1_imm  <= 32'h0;
      end else if (in_fire) begin
         s1_type <= typ;
         s1_imm  <= imm_value;
      end
   end
`else
   assign s2_err  = s1_err;
   assign s2_code = s1_code;
`endif

   // S1: check/pack register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_word  <= 32'h0;
         s1_err   <= 1'b0;
         s1_code  <= ErrOk;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
         s1_word  <= packed_word;
         s1_err   <= chk_err;
         s1_code  <= chk_code;
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   // S2: output register, held while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_word  <= 32'h0;
         out_err   <= 1'b0;
         err_code  <= ErrOk;
      end else if (s1_adv) begin
         out_valid <= 1'b1;
         out_word  <= s1_word;
         out_err   <= s2_err;
         err_code  <= s2_code;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Saturating counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enc_count <= '0;
         err_count <= '0;
      end else if (cnt_clr) begin
         enc_count <= '0;
         err_count <= '0;
      end else if (out_fire) begin
         if (enc_count != '1) enc_count <= enc_count + CntWidth'(1);
         if (out_err && (err_count != '1)) err_count <= err_count + CntWidth'(1);
      end
   end

endmodule
